// File: rtl/barcode_arbiter.sv
// Round-robin arbiter for the shared number source; serialises the latched value as a timed bar stream.
// Grant to Done: 1 + BIT_CYCLES*(NUM_BITS+1) + GAP_CYCLES clocks; requests are sampled only in IDLE, never aborted.
module barcode_arbiter #(
  parameter int NUM_BITS   = 45,
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                ReqA,
  input  logic                ReqB,
  input  logic [NUM_BITS-1:0] StudentNumbers,
  output logic                ClientA,
  output logic                ClientB,
  output logic                GrantA,
  output logic                GrantB,
  output logic                BarOut,
  output logic                BarValid,
  output logic                Busy,
  output logic                DoneA,
  output logic                DoneB,
  output logic                ZeroFault
);

  localparam int MAXC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    START  = 3'd2,
    SHIFT  = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic                last_a, last_a_n;
  logic [NUM_BITS-1:0] sreg, sreg_n, sreg_shl;
  logic [BW-1:0]       bitc, bitc_n;
  logic [CW-1:0]       cyc, cyc_n;
  logic                grant_a_n, grant_b_n, bar_n, valid_n;
  logic                done_a_n, done_b_n, zero_n;

  assign sreg_shl = sreg << 1;

  always_comb begin
    state_n   = state;
    last_a_n  = last_a;
    sreg_n    = sreg;
    bitc_n    = bitc;
    cyc_n     = cyc;
    grant_a_n = GrantA;
    grant_b_n = GrantB;
    bar_n     = 1'b0;
    valid_n   = 1'b0;
    done_a_n  = 1'b0;
    done_b_n  = 1'b0;
    zero_n    = 1'b0;
    case (state)
      IDLE: begin
        grant_a_n = 1'b0;
        grant_b_n = 1'b0;
        // last_a low means B was served last, so A wins a tie
        if (ReqA && (!ReqB || !last_a)) begin
          grant_a_n = 1'b1;
          last_a_n  = 1'b1;
          state_n   = SELECT;
        end else if (ReqB) begin
          grant_b_n = 1'b1;
          last_a_n  = 1'b0;
          state_n   = SELECT;
        end
      end
      SELECT: begin
        sreg_n = StudentNumbers;
        bitc_n = BIT_LAST;
        if (StudentNumbers != '0) begin
          state_n = START;
          cyc_n   = BIT_LOAD;
          bar_n   = 1'b1;
          valid_n = 1'b1;
        end else begin
          state_n = GAP;
          cyc_n   = GAP_LOAD;
          zero_n  = 1'b1;
        end
      end
      START: begin
        valid_n = 1'b1;
        if (cyc == '0) begin
          state_n = SHIFT;
          cyc_n   = BIT_LOAD;
          bar_n   = sreg[NUM_BITS-1];
        end else begin
          cyc_n = cyc - CW'(1);
          bar_n = 1'b1;
        end
      end
      SHIFT: begin
        if (cyc != '0) begin
          cyc_n   = cyc - CW'(1);
          bar_n   = sreg[NUM_BITS-1];
          valid_n = 1'b1;
        end else if (bitc != '0) begin
          sreg_n  = sreg_shl;
          bitc_n  = bitc - BW'(1);
          cyc_n   = BIT_LOAD;
          bar_n   = sreg_shl[NUM_BITS-1];
          valid_n = 1'b1;
        end else begin
          state_n = GAP;
          cyc_n   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cyc != '0) begin
          cyc_n = cyc - CW'(1);
        end else begin
          state_n   = IDLE;
          done_a_n  = GrantA;
          done_b_n  = GrantB;
          grant_a_n = 1'b0;
          grant_b_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      last_a    <= 1'b0;
      sreg      <= '0;
      bitc      <= '0;
      cyc       <= '0;
      ClientA   <= 1'b0;
      ClientB   <= 1'b0;
      GrantA    <= 1'b0;
      GrantB    <= 1'b0;
      BarOut    <= 1'b0;
      BarValid  <= 1'b0;
      Busy      <= 1'b0;
      DoneA     <= 1'b0;
      DoneB     <= 1'b0;
      ZeroFault <= 1'b0;
    end else begin
      state     <= state_n;
      last_a    <= last_a_n;
      sreg      <= sreg_n;
      bitc      <= bitc_n;
      cyc       <= cyc_n;
      ClientA   <= grant_a_n;
      ClientB   <= grant_b_n;
      GrantA    <= grant_a_n;
      GrantB    <= grant_b_n;
      BarOut    <= bar_n;
      BarValid  <= valid_n;
      Busy      <= (state_n != IDLE);
      DoneA     <= done_a_n;
      DoneB     <= done_b_n;
      ZeroFault <= zero_n;
    end
  end

endmodule

// File: tb/tb_barcode_arbiter.sv
// Scoreboard bench for barcode_arbiter: per-cycle expected output vectors are queued as requests are driven.
module tb_barcode_arbiter;

  localparam int NB = 45;
  localparam int BC = 4;
  localparam int GC = 8;
  localparam int L  = 1 + BC + NB*BC + GC;  // 193
  localparam int ZL = 1 + GC;               // 9

  logic          Clock, nReset, ReqA, ReqB;
  logic [NB-1:0] StudentNumbers;
  logic          ClientA, ClientB, GrantA, GrantB, BarOut, BarValid, Busy, DoneA, DoneB, ZeroFault;

  logic [NB-1:0] src_a, src_b;
  logic          force_zero;
  int            n_checks, n_fail;
  logic [9:0]    exp_q[$];

  // Number source: returns the value for whichever client is selected
  assign StudentNumbers = force_zero ? '0 : (ClientA ? src_a : (ClientB ? src_b : '0));

  barcode_arbiter #(.NUM_BITS(NB), .BIT_CYCLES(BC), .GAP_CYCLES(GC)) dut (
    .Clock(Clock), .nReset(nReset), .ReqA(ReqA), .ReqB(ReqB),
    .StudentNumbers(StudentNumbers),
    .ClientA(ClientA), .ClientB(ClientB), .GrantA(GrantA), .GrantB(GrantB),
    .BarOut(BarOut), .BarValid(BarValid), .Busy(Busy),
    .DoneA(DoneA), .DoneB(DoneB), .ZeroFault(ZeroFault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [9:0] obs_now();
    return {GrantA, GrantB, ClientA, ClientB, BarOut, BarValid, Busy, DoneA, DoneB, ZeroFault};
  endfunction

  // k = cycle after the edge on which the request was taken in IDLE
  function automatic void push_txn(input bit is_a, input logic [NB-1:0] v);
    logic [9:0] e;
    bit         z;
    int         last;
    z    = (v == '0);
    last = z ? ZL : L;
    for (int k = 0; k <= last; k++) begin
      e = '0;
      if (k < last) begin
        e[9] = is_a; e[8] = !is_a; e[7] = is_a; e[6] = !is_a; e[3] = 1'b1;
        if (z) begin
          e[0] = (k == 1);
        end else if (k >= 1 && k <= BC) begin
          e[5] = 1'b1; e[4] = 1'b1;
        end else if (k > BC && k <= BC + NB*BC) begin
          e[5] = v[NB-1-(k-1-BC)/BC]; e[4] = 1'b1;
        end
      end else begin
        e[2] = is_a; e[1] = !is_a;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    logic [9:0] o, x;
    nReset = 1'b0; ReqA = 1'b0; ReqB = 1'b0; force_zero = 1'b0;
    src_a = 45'd20460192049719; src_b = 45'h0F0F12345678;
    #3;
    o = obs_now(); n_checks++;
    if (o !== 10'b0) begin n_fail++; $display("FAIL reset_initial got=%b exp=%b", o, 10'b0); end
    ReqA = 1'b1; ReqB = 1'b1;
    repeat (3) @(negedge Clock);
    o = obs_now(); n_checks++;
    if (o !== 10'b0) begin n_fail++; $display("FAIL reset_held got=%b exp=%b", o, 10'b0); end
    ReqA = 1'b0; ReqB = 1'b0;
    nReset = 1'b1;
    @(negedge Clock);
    o = obs_now(); x = '0; n_checks++;
    if (o !== x) begin n_fail++; $display("FAIL reset_idle got=%b exp=%b", o, x); end
  endtask

  task automatic test_single();
    logic [9:0] o, x;
    int done_at;
    done_at = -1;
    ReqA = 1'b1;
    push_txn(1'b1, src_a);
    for (int i = 0; i < L + 3; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL single cyc=%0d got=%b exp=%b", i, o, x); end
      if (DoneA && done_at < 0) done_at = i;
      if (i == 0) ReqA = 1'b0;
    end
    n_checks++;
    if (done_at !== L) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", done_at, L); end
  endtask

  task automatic test_tie();
    logic [9:0] o, x;
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1; ReqA = 1'b1; ReqB = 1'b1;
    push_txn(1'b1, src_a);
    push_txn(1'b0, src_b);
    push_txn(1'b1, src_a);
    for (int i = 0; i < 3*(L+1) + 2; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL tie cyc=%0d got=%b exp=%b", i, o, x); end
      if (i == 2*(L+1)) begin ReqA = 1'b0; ReqB = 1'b0; end
    end
  endtask

  task automatic test_mid_change();
    logic [9:0] o, x;
    int done_at;
    done_at = -1;
    ReqA = 1'b1;
    push_txn(1'b1, src_a);
    push_txn(1'b0, src_b);
    for (int i = 0; i < 2*(L+1) + 2; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL midchange cyc=%0d got=%b exp=%b", i, o, x); end
      if (DoneA && done_at < 0) done_at = i;
      if (i == 50) begin ReqA = 1'b0; ReqB = 1'b1; end
      if (i == L + 1) ReqB = 1'b0;
    end
    n_checks++;
    if (done_at !== L) begin n_fail++; $display("FAIL midchange_latency got=%0d exp=%0d", done_at, L); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] o, x;
    ReqA = 1'b1;
    push_txn(1'b1, src_a);
    for (int i = 0; i < 61; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL resetmid_pre cyc=%0d got=%b exp=%b", i, o, x); end
      if (i == 0) ReqA = 1'b0;
    end
    #2 nReset = 1'b0;
    #1;
    o = obs_now(); n_checks++;
    if (o !== 10'b0) begin n_fail++; $display("FAIL resetmid_async got=%b exp=%b", o, 10'b0); end
    exp_q.delete();
    @(negedge Clock);
    nReset = 1'b1; ReqA = 1'b1; ReqB = 1'b1;
    push_txn(1'b1, src_a);
    for (int i = 0; i < L + 3; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL resetmid_tie cyc=%0d got=%b exp=%b", i, o, x); end
      if (i == 0) begin ReqA = 1'b0; ReqB = 1'b0; end
    end
  endtask

  task automatic test_zero();
    logic [9:0] o, x;
    int done_at;
    done_at = -1;
    ReqB = 1'b1; force_zero = 1'b1;
    push_txn(1'b0, '0);
    for (int i = 0; i < ZL + 3; i++) begin
      @(negedge Clock);
      o = obs_now();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 10'b0;
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL zero cyc=%0d got=%b exp=%b", i, o, x); end
      if (DoneB && done_at < 0) done_at = i;
      if (i == 0) ReqB = 1'b0;
    end
    force_zero = 1'b0;
    n_checks++;
    if (done_at !== ZL) begin n_fail++; $display("FAIL zero_latency got=%0d exp=%0d", done_at, ZL); end
  endtask

  task automatic test_random();
    bit pend_a, pend_b;
    pend_a = 1'b0; pend_b = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge Clock);
      n_checks++;
      if ((ClientA & ClientB) !== 1'b0 || ClientA !== GrantA || ClientB !== GrantB) begin
        n_fail++;
        $display("FAIL random_select cyc=%0d got ca=%b cb=%b ga=%b gb=%b exp exclusive and equal", i, ClientA, ClientB, GrantA, GrantB);
      end
      if (GrantA) pend_a = 1'b1;
      if (GrantB) pend_b = 1'b1;
      if (DoneA) begin
        n_checks++;
        if (pend_a !== 1'b1) begin n_fail++; $display("FAIL random_doneA cyc=%0d got pending=%b exp=1", i, pend_a); end
        pend_a = 1'b0;
      end
      if (DoneB) begin
        n_checks++;
        if (pend_b !== 1'b1) begin n_fail++; $display("FAIL random_doneB cyc=%0d got pending=%b exp=1", i, pend_b); end
        pend_b = 1'b0;
      end
      ReqA = 1'($urandom_range(0, 1));
      ReqB = 1'($urandom_range(0, 1));
      force_zero = ($urandom_range(0, 7) == 0);
      src_a = {13'($urandom), 32'($urandom)};
      src_b = {13'($urandom), 32'($urandom)};
    end
    ReqA = 1'b0; ReqB = 1'b0; force_zero = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_tie();
    test_mid_change();
    test_reset_mid();
    test_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
